// File: rtl/sr_excite_driver_pkg.sv
// Shared types and encodings for the SR excitation driver.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {s,r} drive encodings
    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RESET = 2'b01;
    localparam logic [1:0] SR_SET   = 2'b10;

    localparam int MODE_MIN    = 0;
    localparam int MODE_FORCED = 1;

endpackage

// File: rtl/sr_excite_driver_if.sv
// Load handshake, flop feedback and status bundle for sr_excite_driver.
interface sr_excite_driver_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic             repeat_en;
    logic             abort;
    logic             q_fb;
    logic             s;
    logic             r;
    logic             busy;
    logic             done;
    logic             err_flag;
    logic [CNT_W-1:0] err_cnt;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output load_valid, pattern, repeat_en, abort, q_fb,
        input  load_ready, s, r, busy, done, err_flag, err_cnt, bit_idx
    );

    modport slave (
        input  load_valid, pattern, repeat_en, abort, q_fb,
        output load_ready, s, r, busy, done, err_flag, err_cnt, bit_idx
    );

endinterface

// File: rtl/sr_excite_driver_excite.sv
// Inverse SR characteristic: the {s,r} needed to move q to target t.
module sr_excite
    import sr_pkg::*;
(
    input  logic       t,
    input  logic       q,
    input  logic       mode,
    output logic [1:0] sr
);

    always_comb begin
        sr = SR_HOLD;
        if (mode || (t != q)) begin
            sr = t ? SR_SET : SR_RESET;
        end
    end

endmodule

// File: rtl/sr_excite_driver.sv
// Plays a target pattern into a downstream SR flop one bit per DRIVE/CHECK
// pair and counts cycles where the flop's q disagrees with the target.
module sr_excite_driver
    import sr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int MODE  = MODE_MIN
) (
    input  logic              clk,
    input  logic              rst,
    sr_excite_driver_if.slave bus
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic             FORCED   = 1'(MODE == MODE_FORCED);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pat, w_pat_nxt;
    logic             r_rep, w_rep_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_s, r_r;
    logic             r_done, w_done_nxt;
    logic             r_err_flag, w_err_flag_nxt;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic             w_enter_drive;
    logic             w_t_nxt;
    logic             w_q;
    logic             w_miss;
    logic [1:0]       w_excite;
    logic [1:0]       w_sr_nxt;

    // Unknown feedback excites as q=0 but always counts as a mismatch
    assign w_q    = (bus.q_fb === 1'b1);
    assign w_miss = (bus.q_fb !== r_pat[r_idx]);

    sr_excite u_excite (
        .t    (w_t_nxt),
        .q    (w_q),
        .mode (FORCED),
        .sr   (w_excite)
    );

    assign w_sr_nxt = w_enter_drive ? w_excite : SR_HOLD;

    always_comb begin
        w_state_nxt    = r_state;
        w_pat_nxt      = r_pat;
        w_rep_nxt      = r_rep;
        w_idx_nxt      = r_idx;
        w_done_nxt     = 1'b0;
        w_err_flag_nxt = r_err_flag;
        w_err_cnt_nxt  = r_err_cnt;
        w_enter_drive  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_valid) begin
                    w_pat_nxt      = bus.pattern;
                    w_rep_nxt      = bus.repeat_en;
                    w_err_flag_nxt = 1'b0;
                    w_err_cnt_nxt  = '0;
                    w_idx_nxt      = '0;
                    w_state_nxt    = DRIVE;
                    w_enter_drive  = 1'b1;
                end
            end
            DRIVE: begin
                w_state_nxt = bus.abort ? IDLE : CHECK;
            end
            CHECK: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (w_miss) begin
                        w_err_flag_nxt = 1'b1;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                    end
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt     = r_idx + 1'b1;
                        w_state_nxt   = DRIVE;
                        w_enter_drive = 1'b1;
                    end else if (r_rep) begin
                        w_idx_nxt     = '0;
                        w_state_nxt   = DRIVE;
                        w_enter_drive = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Target of the bit about to be driven, from the post-transition pattern/index
        w_t_nxt = w_pat_nxt[w_idx_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_rep      <= 1'b0;
            r_idx      <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_done     <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pat      <= w_pat_nxt;
            r_rep      <= w_rep_nxt;
            r_idx      <= w_idx_nxt;
            r_s        <= w_sr_nxt[1];
            r_r        <= w_sr_nxt[0];
            r_done     <= w_done_nxt;
            r_err_flag <= w_err_flag_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    a_no_set_and_reset : assert property (@(posedge clk) disable iff (rst) !(r_s && r_r));

    assign bus.load_ready = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.s          = r_s;
    assign bus.r          = r_r;
    assign bus.done       = r_done;
    assign bus.err_flag   = r_err_flag;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.bit_idx    = r_idx;

endmodule

// File: doc/sr_excite_driver.md
Name: sr_excite_driver

Overview:
- Driver on the input side of an SR flip-flop: plays a loaded WIDTH-bit target pattern into a downstream positive-edge SR flip-flop, one bit per step.
- Each step it computes the SR excitation (s, r) from the target bit and the current q_fb, i.e. the inverse of the SR characteristic table.
- It then checks the flop's q_fb against the target and counts mismatches.
- Used as a stimulus/self-check block alongside the team's SR flip-flop models.

Parameters:
- WIDTH, 8, pattern length in bits; must be >= 2.
- CNT_W, 8, error counter width.
- MODE, 0, excitation policy:
  - 0 = minimal: drive only on change, otherwise hold.
  - 1 = forced: drive set or reset on every bit.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- load_valid, in, 1, pattern offer.
- load_ready, out, 1, high when a pattern can be accepted.
- pattern, in, WIDTH, target q sequence, played LSB first.
- repeat_en, in, 1, sampled at load; replays the pattern continuously.
- abort, in, 1, synchronous stop.
- q_fb, in, 1, q of the downstream flip-flop.
- s, out, 1, set drive (registered).
- r, out, 1, reset drive (registered).
- busy, out, 1, high in DRIVE or CHECK.
- done, out, 1, one-cycle pulse after the last bit's CHECK (non-repeat only).
- err_flag, out, 1, sticky mismatch flag.
- err_cnt, out, CNT_W, saturating mismatch count.
- bit_idx, out, clog2(WIDTH), index of the current bit.

Behaviour:
- Reset (async, rst high):
  - state=IDLE.
  - s=r=0, done=0, busy=0, err_flag=0, err_cnt=0, bit_idx=0.
  - load_ready=1, since load_ready is (state==IDLE).
  - s and r go to 0 immediately, without a clock edge.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - load_valid&load_ready → capture pattern and repeat_en, clear err_flag and err_cnt, set bit_idx=0, go to DRIVE.
  - Otherwise stay; s=r=0.
- Entering DRIVE (registered): {s,r} <= excite(t=pattern[bit_idx], q=q_fb sampled at that edge). Held for exactly one cycle.
- excite, MODE 0:
  - t==q → 00 (hold).
  - t=1,q=0 → 10 (set).
  - t=0,q=1 → 01 (reset).
- excite, MODE 1: t=1 → 10, t=0 → 01.
- s&r==1 must never occur (assertion).
- DRIVE → CHECK unconditionally. {s,r}=00 during CHECK. The downstream flop captures at the DRIVE→CHECK edge.
- End of CHECK:
  - Compare q_fb with t. On mismatch: err_flag<=1 and err_cnt<=err_cnt+1, saturating at all-ones.
  - Not the last bit: bit_idx+1, go to DRIVE.
  - Last bit (bit_idx==WIDTH-1):
    - repeat_en → bit_idx=0, DRIVE; no done pulse.
    - Otherwise → done=1 for one cycle, IDLE.
- Timing: 2 cycles per bit. Non-repeat completes 2*WIDTH cycles after the accept edge. done is high during cycle 2*WIDTH+1, the first IDLE cycle.
- abort:
  - High at any edge while busy → IDLE, s=r=0, no done.
  - err_flag and err_cnt are retained.
  - abort takes precedence over every transition. It is ignored in IDLE.
- load_valid while busy: ignored, since load_ready=0. The pattern register is not modified.
- q_fb X or Z: compared as a mismatch (!==). Excitation treats it as q=0.

Decomposition:
- Package sr_pkg:
  - state enum {IDLE, DRIVE, CHECK}.
  - SR encodings SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10.
  - MODE_MIN=0, MODE_FORCED=1.
- Sub-module sr_excite: purely combinational (t, q, mode) → {s,r}. Instantiated once; the registered outputs live in the top.
- Bench: positive-edge SR flip-flop model with async active-high rst feeding q_fb.

Test Plan:
- MODE 0, flop q=0, pattern 8'hA6 (bits LSB first 0,1,1,0,0,1,0,1) → {s,r} per DRIVE = 00,10,00,01,00,10,01,10; done pulses in cycle 17 after accept; err_cnt=0, err_flag=0.
- MODE 1, same pattern → {s,r} = 01,10,10,01,01,10,01,10; final q_fb=1; err_cnt=0.
- q_fb tied to 0, pattern 8'hFF, MODE 0 → s=1 on every DRIVE; err_cnt=8; err_flag=1. A new load clears both to 0.
- CNT_W=2, repeat_en=1, q_fb tied to 0, pattern 8'hFF → err_cnt saturates at 3 after the third CHECK and stays 3; done never pulses; abort after 40 cycles → IDLE, load_ready=1, s=r=0.
- Mid-run, bit_idx=3 in DRIVE with s=1: assert rst between edges → s=0 immediately, state IDLE, err_cnt=0. load_valid pulsed during busy → pattern unchanged and the run completes normally.
- Full run with random patterns and both MODEs → s&r never 1, and each CHECK q_fb equals the target bit.
